fp24_convert_arbiter: RTL and testbench

Shares one integer-to-FP24 converter (`make_fp24`, 1-cycle registered latency) between NUM_REQ requesters.
- Round-robin arbitration between requesters.
- Credit-based issue with an output FIFO, so the fixed-latency converter never overflows under backpressure.
- Each result is returned on a single response channel, tagged with the requester index.
- Sits between the per-pixel and per-ray integer producers and the FP24 math pipelines.

---
 rtl/fp24_convert_arbiter.sv | 139 +++++++++++++
 tb/tb_fp24_convert_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp24_convert_arbiter.sv
// rtl/fp24_convert_arbiter.sv - round-robin, credit-gated sharing of one integer-to-FP24 converter
module fp24_convert_arbiter #(
  parameter int WIDTH      = 32,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]                  req_data,
  output logic                                      resp_valid,
  input  logic                                      resp_ready,
  output logic [23:0]                               resp_data,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] resp_id,
  output logic                                      busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  // Integer to FP24: sign, exp = msb index + 63, mantissa = truncated bits below the leading one.
  function automatic logic [23:0] make_fp24(input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0]  mag;
    logic [WIDTH+15:0] norm;
    logic [6:0]        exp_f;
    int                msb;
    mag = n[WIDTH-1] ? ((~n) + {{(WIDTH-1){1'b0}}, 1'b1}) : n;
    msb = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) msb = i;
    end
    norm  = {mag, 16'h0000} << (WIDTH - 1 - msb);
    exp_f = 7'(msb + 63);
    if (mag == '0) make_fp24 = 24'h000000;
    else           make_fp24 = {n[WIDTH-1], exp_f, norm[WIDTH+14 -: 16]};
  endfunction

  logic [ID_W-1:0]  rr_ptr;
  logic             conv_valid;
  logic [WIDTH-1:0] conv_data;
  logic [ID_W-1:0]  conv_id;

  logic [23:0]      mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic             issue_ok;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             push;
  logic             pop;
  logic [23:0]      push_data;

  // A same-cycle pop deliberately earns no credit; the converter stage counts as an occupied slot.
  assign issue_ok  = (int'(count) + int'(conv_valid)) < FIFO_DEPTH;
  assign push      = conv_valid;
  assign pop       = resp_valid & resp_ready;
  assign push_data = make_fp24(conv_data);

  // Round-robin search from rr_ptr upward with wrap; nothing is granted while in reset or out of credit.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    req_ready   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (rst && issue_ok && !grant_valid && (j >= int'(rr_ptr)) && req_valid[j]) begin
        grant_valid  = 1'b1;
        grant_idx    = ID_W'(j);
        grant_data   = req_data[j*WIDTH +: WIDTH];
        req_ready[j] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (rst && issue_ok && !grant_valid && req_valid[j]) begin
        grant_valid  = 1'b1;
        grant_idx    = ID_W'(j);
        grant_data   = req_data[j*WIDTH +: WIDTH];
        req_ready[j] = 1'b1;
      end
    end
  end

  // Arbiter pointer and converter input stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      conv_valid <= 1'b0;
      conv_data  <= '0;
      conv_id    <= '0;
    end else begin
      conv_valid <= grant_valid;
      if (grant_valid) begin
        conv_data <= grant_data;
        conv_id   <= grant_idx;
        rr_ptr    <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  // FIFO storage; contents are only visible through resp_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_id[wr_ptr]   <= conv_id;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (int'(wr_ptr) == FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (int'(rd_ptr) == FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign resp_valid = (count != '0);
  assign resp_data  = resp_valid ? mem_data[rd_ptr] : 24'h000000;
  assign resp_id    = resp_valid ? mem_id[rd_ptr] : '0;
  assign busy       = conv_valid | (count != '0);

  // Credit accounting must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst) !(push && (int'(count) == FIFO_DEPTH)));

endmodule

// File: tb/tb_fp24_convert_arbiter.sv
// tb/tb_fp24_convert_arbiter.sv - randomized and directed checks against a behavioural model
module tb_fp24_convert_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [23:0]  resp_data;
  logic [1:0]   resp_id;
  logic         busy;

  fp24_convert_arbiter #(.WIDTH(32), .NUM_REQ(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [23:0] d;
  } item_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_data [4];
  item_t       m_fifo [$];
  item_t       m_item;
  int          m_inflight = 0;
  int          m_ptr = 0;
  int          s_grant;
  logic        s_resp_valid;
  logic [23:0] s_resp_data;
  logic [1:0]  s_resp_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_fp24(input logic [31:0] n);
    longint v;
    longint mag;
    longint m;
    int     e;
    v = longint'($signed(n));
    if (v == 0) return 24'h000000;
    mag = (v < 0) ? -v : v;
    e = 0;
    while ((64'sd1 <<< (e + 1)) <= mag) e++;
    m = ((mag - (64'sd1 <<< e)) <<< 16) >>> e;
    return {(v < 0) ? 1'b1 : 1'b0, 7'(e + 63), 16'(m)};
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h80000000;
      1:       return 32'h7fffffff;
      2:       return 32'hffffffff;
      3:       return 32'h00000000;
      4:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(input logic [3:0] v, input logic rr);
    int   eg;
    logic exp_valid;
    @(negedge clk);
    req_valid  = v;
    resp_ready = rr;
    req_data   = {cur_data[3], cur_data[2], cur_data[1], cur_data[0]};
    #1;
    eg = -1;
    if (m_fifo.size() + m_inflight < 4) begin
      for (int k = 0; k < 4; k++) begin
        if (eg < 0 && v[(m_ptr + k) % 4]) eg = (m_ptr + k) % 4;
      end
    end
    exp_valid = (m_fifo.size() > 0);
    chk("req_ready", 32'(req_ready), (eg >= 0) ? (32'd1 << eg) : 32'd0);
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("resp_data", 32'(resp_data), 32'(m_fifo[0].d));
      chk("resp_id", 32'(resp_id), 32'(m_fifo[0].id));
    end
    chk("busy", 32'(busy), 32'((m_inflight != 0) || exp_valid));
    s_grant = -1;
    for (int k = 0; k < 4; k++) if (req_ready[k] && v[k]) s_grant = k;
    s_resp_valid = resp_valid;
    s_resp_data  = resp_data;
    s_resp_id    = resp_id;
    @(posedge clk);
    if (exp_valid && rr) void'(m_fifo.pop_front());
    if (m_inflight != 0) m_fifo.push_back(m_item);
    m_inflight = (eg >= 0) ? 1 : 0;
    if (eg >= 0) begin
      m_item.id = eg;
      m_item.d  = ref_fp24(cur_data[eg]);
      m_ptr     = (eg + 1) % 4;
      cur_data[eg] = rand_val();
    end
  endtask

  task automatic send_one(input int id, input logic [31:0] val);
    int n;
    cur_data[id] = val;
    n = 0;
    s_grant = -1;
    while (s_grant != id && n < 20) begin
      cycle(4'b0001 << id, 1'b1);
      n++;
    end
    if (s_grant != id) chk("send_timeout", 32'(s_grant), 32'(id));
  endtask

  logic [31:0] dir_in  [7] = '{32'd1, 32'd3, 32'hfffffffa, 32'd0, 32'h80000000, 32'h7fffffff, 32'hffffffff};
  logic [23:0] dir_out [7] = '{24'h3F0000, 24'h408000, 24'hC18000, 24'h000000, 24'hDE0000, 24'h5DFFFF, 24'hBF0000};

  initial begin
    int prev;
    int accepts;
    rst = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    req_data = '0;
    for (int i = 0; i < 4; i++) cur_data[i] = rand_val();
    #2;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single requester directed values with two-cycle latency.
    for (int t = 0; t < 7; t++) begin
      send_one(2, dir_in[t]);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b1);
      chk("dir_valid", 32'(s_resp_valid), 32'd1);
      chk("dir_data", 32'(s_resp_data), 32'(dir_out[t]));
      chk("dir_id", 32'(s_resp_id), 32'd2);
    end
    cycle(4'b0000, 1'b1);

    // All requesters busy: one grant per cycle in rotation.
    prev = -1;
    for (int t = 0; t < 12; t++) begin
      cycle(4'b1111, 1'b1);
      if (prev >= 0) chk("rr_order", 32'(s_grant), 32'((prev + 1) % 4));
      if (t >= 3) chk("no_bubble", 32'(s_resp_valid), 32'd1);
      prev = s_grant;
    end
    for (int t = 0; t < 4; t++) cycle(4'b0000, 1'b1);

    // Backpressure: exactly FIFO_DEPTH accepts, then stalled.
    accepts = 0;
    for (int t = 0; t < 8; t++) begin
      cycle(4'b1111, 1'b0);
      if (s_grant >= 0) accepts++;
    end
    chk("bp_accepts", 32'(accepts), 32'd4);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    for (int t = 0; t < 10; t++) cycle(4'b1111, 1'b1);
    for (int t = 0; t < 6; t++) cycle(4'b0000, 1'b1);

    // Fairness with idle requesters 0 and 2.
    prev = -1;
    for (int t = 0; t < 8; t++) begin
      cycle(4'b1010, 1'b1);
      if (prev >= 0) chk("skip_order", 32'(s_grant), (prev == 1) ? 32'd3 : 32'd1);
      prev = s_grant;
    end
    for (int t = 0; t < 4; t++) cycle(4'b0000, 1'b1);

    // Async reset with three results queued and one in flight.
    for (int t = 0; t < 4; t++) cycle(4'b1111, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_data", 32'(resp_data), 32'd0);
    chk("arst_resp_id", 32'(resp_id), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    m_fifo.delete();
    m_inflight = 0;
    m_ptr = 0;
    cycle(4'b1111, 1'b1);
    chk("arst_first_grant", 32'(s_grant), 32'd0);
    for (int t = 0; t < 6; t++) cycle(4'b0000, 1'b1);

    // Random traffic.
    for (int t = 0; t < 2000; t++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    for (int t = 0; t < 10; t++) cycle(4'b0000, 1'b1);
    chk("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
